if_prefetch_queue: RTL and testbench

Instruction prefetch unit that sits directly upstream of the FETCH pipeline register and replaces the bare PC/adder/Inst_Mem path. It runs ahead of the core, issuing word-addressed requests to an instruction memory with a variable-latency req/ack handshake. It buffers returned instructions with their PC+1 in a small FIFO and presents the head entry to FETCH. Branch/jump redirects flush the queue and restart fetching at the new target, including when a memory request is still outstanding.

---
 rtl/if_prefetch_queue.sv | 119 +++++++++++
 tb/tb_if_prefetch_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: runs ahead of FETCH, issuing word-addressed imem
// requests and buffering {inst, pc+1} pairs; redirects flush and restart fetch.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     deq_en,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pcp1,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pending_target;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          active;
  logic          pending;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pcp1 [DEPTH];

  logic deq;
  logic enq;
  logic space;

  // A request left unacked last cycle is held regardless of redirect or space,
  // so the address stays stable until the memory accepts it.
  always_comb begin
    inst_valid = (count != '0);
    deq        = deq_en && inst_valid && !redirect;
    space      = (count != FULL) || deq;
    imem_req   = active && ((state == DRAIN) || pending || (!redirect && space));
    enq        = imem_req && imem_ack && (state == RUN) && !redirect;
    imem_addr  = fetch_pc;
    occupancy  = count;
    inst       = inst_valid ? q_inst[rd_ptr] : '0;
    inst_pcp1  = inst_valid ? q_pcp1[rd_ptr] : '0;
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pcp1[wr_ptr] <= fetch_pc + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state          <= RUN;
      fetch_pc       <= RESET_PC;
      pending_target <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      active         <= 1'b0;
      pending        <= 1'b0;
    end else begin
      active  <= 1'b1;
      pending <= imem_req && !imem_ack;
      unique case (state)
        RUN: begin
          if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (imem_req && !imem_ack) begin
              pending_target <= redirect_pc;
              state          <= DRAIN;
            end else begin
              fetch_pc <= redirect_pc;
            end
          end else begin
            if (enq) begin
              wr_ptr   <= wr_ptr + AW'(1);
              fetch_pc <= fetch_pc + 32'd1;
            end
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            unique case ({enq, deq})
              2'b10:   count <= count + (AW+1)'(1);
              2'b01:   count <= count - (AW+1)'(1);
              default: count <= count;
            endcase
          end
        end
        DRAIN: begin
          if (redirect) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            pending_target <= redirect_pc;
          end
          // Old request's data is dropped; restart at the newest target.
          if (imem_ack) begin
            fetch_pc <= redirect ? redirect_pc : pending_target;
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: memory word k = 0x1000_0000 + k,
// second instance exercises PC wrap at 32'hFFFF_FFFE.
module tb_if_prefetch_queue;

  logic        CLK = 1'b0;
  logic        RST, redirect, deq_en, imem_ack;
  logic [31:0] redirect_pc;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pcp1;
  logic [2:0]  occupancy;

  logic        RST2;
  logic        imem_req2, inst_valid2;
  logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pcp12;
  logic [2:0]  occupancy2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  assign imem_rdata  = 32'h1000_0000 + imem_addr;
  assign imem_rdata2 = 32'h1000_0000 + imem_addr2;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_en(deq_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pcp1(inst_pcp1), .occupancy(occupancy)
  );

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) u_wrap (
    .CLK(CLK), .RST(RST2), .redirect(1'b0), .redirect_pc(32'h0),
    .deq_en(1'b1), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(1'b1), .imem_rdata(imem_rdata2), .inst_valid(inst_valid2),
    .inst(inst2), .inst_pcp1(inst_pcp12), .occupancy(occupancy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] i, input logic [31:0] p);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, "_inst"}, inst, i);
    check({tag, "_pcp1"}, inst_pcp1, p);
  endtask

  initial begin
    RST = 1'b0; RST2 = 1'b0; redirect = 1'b0; redirect_pc = '0;
    deq_en = 1'b0; imem_ack = 1'b1;
    tick(); tick();
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pcp1", inst_pcp1, 32'h0);
    check("rst_occ", {29'b0, occupancy}, 32'd0);
    check("rst2_addr", imem_addr2, 32'hFFFF_FFFE);

    // Fill with deq_en=0 until full
    RST = 1'b1;
    tick(); #1;
    check("e0_req", {31'b0, imem_req}, 32'd1);
    check("e0_addr", imem_addr, 32'h0);
    check("e0_valid", {31'b0, inst_valid}, 32'd0);
    tick(); #1;
    chk_head("e1", 32'h1000_0000, 32'h1);
    check("e1_occ", {29'b0, occupancy}, 32'd1);
    tick(); tick(); tick(); #1;
    check("full_occ", {29'b0, occupancy}, 32'd4);
    check("full_req", {31'b0, imem_req}, 32'd0);
    check("full_addr", imem_addr, 32'h4);
    tick(); #1;
    check("hold_occ", {29'b0, occupancy}, 32'd4);
    check("hold_req", {31'b0, imem_req}, 32'd0);

    // One-cycle dequeue on a full queue re-requests the same cycle
    deq_en = 1'b1; #1;
    check("popreq_req", {31'b0, imem_req}, 32'd1);
    check("popreq_addr", imem_addr, 32'h4);
    tick(); deq_en = 1'b0; #1;
    check("pop_occ", {29'b0, occupancy}, 32'd4);
    chk_head("pop", 32'h1000_0001, 32'h2);
    check("pop_req", {31'b0, imem_req}, 32'd0);
    check("pop_addr", imem_addr, 32'h5);

    // Streaming
    deq_en = 1'b1;
    tick(); #1;
    chk_head("s1", 32'h1000_0002, 32'h3);
    check("s1_occ", {29'b0, occupancy}, 32'd4);
    tick(); #1;
    chk_head("s2", 32'h1000_0003, 32'h4);

    // Dequeue without ack: 3 entries left, request for 7 pending
    imem_ack = 1'b0;
    tick(); #1;
    check("p3_occ", {29'b0, occupancy}, 32'd3);
    check("p3_addr", imem_addr, 32'h7);
    chk_head("p3", 32'h1000_0004, 32'h5);

    // Redirect to 0x40 acked in the same cycle
    redirect = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b1; #1;
    check("rd_req_held", {31'b0, imem_req}, 32'd1);
    tick(); redirect = 1'b0; #1;
    check("rd1_occ", {29'b0, occupancy}, 32'd0);
    check("rd1_valid", {31'b0, inst_valid}, 32'd0);
    check("rd1_req", {31'b0, imem_req}, 32'd1);
    check("rd1_addr", imem_addr, 32'h40);
    tick(); imem_ack = 1'b0; #1;
    chk_head("rd2", 32'h1000_0040, 32'h41);
    check("rd2_addr", imem_addr, 32'h41);

    // Redirect while request for 0x41 waits; DRAIN, then a second redirect
    tick(); redirect = 1'b1; redirect_pc = 32'h70; #1;
    check("w0_occ", {29'b0, occupancy}, 32'd0);
    check("w0_req", {31'b0, imem_req}, 32'd1);
    check("w0_addr", imem_addr, 32'h41);
    tick(); redirect_pc = 32'h80; #1;
    check("w1_req", {31'b0, imem_req}, 32'd1);
    check("w1_addr", imem_addr, 32'h41);
    check("w1_valid", {31'b0, inst_valid}, 32'd0);
    tick(); redirect = 1'b0; #1;
    check("w2_addr", imem_addr, 32'h41);
    tick(); imem_ack = 1'b1; #1;
    check("w3_req", {31'b0, imem_req}, 32'd1);
    check("w3_addr", imem_addr, 32'h41);
    tick(); deq_en = 1'b0; #1;
    check("dr_valid", {31'b0, inst_valid}, 32'd0);
    check("dr_occ", {29'b0, occupancy}, 32'd0);
    check("dr_req", {31'b0, imem_req}, 32'd1);
    check("dr_addr", imem_addr, 32'h80);
    tick(); imem_ack = 1'b0; #1;
    chk_head("dr2", 32'h1000_0080, 32'h81);
    check("dr2_occ", {29'b0, occupancy}, 32'd1);

    // Enter DRAIN again, then reset
    tick(); redirect = 1'b1; redirect_pc = 32'h100; #1;
    tick(); redirect = 1'b0; RST = 1'b0; #1;
    check("dn_req", {31'b0, imem_req}, 32'd1);
    check("dn_addr", imem_addr, 32'h81);
    tick(); RST = 1'b1; imem_ack = 1'b1; #1;
    check("mr_req", {31'b0, imem_req}, 32'd0);
    check("mr_addr", imem_addr, 32'h0);
    check("mr_valid", {31'b0, inst_valid}, 32'd0);
    check("mr_inst", inst, 32'h0);
    check("mr_pcp1", inst_pcp1, 32'h0);
    check("mr_occ", {29'b0, occupancy}, 32'd0);
    tick(); #1;
    check("mr1_req", {31'b0, imem_req}, 32'd1);
    check("mr1_addr", imem_addr, 32'h0);
    tick(); #1;
    chk_head("mr2", 32'h1000_0000, 32'h1);

    // PC wrap on the second instance
    RST2 = 1'b1;
    tick(); #1;
    check("wr0_req", {31'b0, imem_req2}, 32'd1);
    check("wr0_addr", imem_addr2, 32'hFFFF_FFFE);
    tick(); #1;
    check("wr1_valid", {31'b0, inst_valid2}, 32'd1);
    check("wr1_inst", inst2, 32'h0FFF_FFFE);
    check("wr1_pcp1", inst_pcp12, 32'hFFFF_FFFF);
    tick(); #1;
    check("wr2_inst", inst2, 32'h0FFF_FFFF);
    check("wr2_pcp1", inst_pcp12, 32'h0000_0000);
    tick(); #1;
    check("wr3_inst", inst2, 32'h1000_0000);
    check("wr3_pcp1", inst_pcp12, 32'h0000_0001);
    check("wr3_occ", {29'b0, occupancy2}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
